pec_tcdm_responder: RTL and testbench
=====================================

// Module: pec_tcdm_responder
// PURPOSE
//  Word-interleaved, multi-bank TCDM scratchpad that acts as the slave end of the
//  streamer's TCDM master ports. It arbitrates per bank, commits byte-masked writes,
//  and returns read data on a fixed one-cycle response path.
//  Used as the L1 model in PEC subsystem benches and as a standalone scratchpad.
// PARAMETERS
//  NB_PORTS     2   number of TCDM master ports served
//  NB_BANKS     4   number of word-interleaved banks (power of 2)
//  BANK_WORDS   256 32-bit words per bank (power of 2)
//  STALL_PERIOD 0   0 = never stall; N>0 = deny all grants one cycle in every N
// PORTS
//  clk_i      in   1              clock
//  rst_i      in   1              synchronous reset, active-high
//  req_i      in   NB_PORTS       request per port
//  add_i      in   NB_PORTS x 32  byte address per port
//  wen_i      in   NB_PORTS       1 = read, 0 = write
//  wdata_i    in   NB_PORTS x 32  write data
//  be_i       in   NB_PORTS x 4   byte enables (write only)
//  gnt_o      out  NB_PORTS       grant, combinational in the request cycle
//  r_valid_o  out  NB_PORTS       response valid, one cycle after grant
//  r_rdata_o  out  NB_PORTS x 32  read data, qualified by r_valid_o
//  r_opc_o    out  NB_PORTS       error flag, tied to 0
// BEHAVIOUR
//  Decided: one clock; reset is synchronous and active-high (clk_i, rst_i).
//  Address map: widx = add_i[31:2]; bank = widx % NB_BANKS;
//   row = (widx / NB_BANKS) % BANK_WORDS. Upper bits are ignored, so addresses wrap
//   silently. add_i[1:0] are ignored.
//  Arbitration, per bank, with round-robin pointer rr_q[b] (one per bank):
//   - One requester to a bank: that requester is granted.
//   - Two or more requesters: the first requesting port at or after rr_q[b] (modulo
//     NB_PORTS) is granted. rr_q[b] then becomes granted+1 (mod NB_PORTS).
//   - rr_q[b] updates only on a conflict cycle.
//   - Ports on different banks are all granted in the same cycle.
//  Stall: stall_cnt counts 0..STALL_PERIOD-1 and wraps. When stall_cnt == STALL_PERIOD-1,
//   all gnt_o = 0 and rr_q holds. The counter runs regardless of traffic.
//  Write, on a granted cycle with wen=0: at the clock edge, bytes with be=1 are written
//   to mem[bank][row]. be=0 leaves the word unchanged.
//  Read, on a granted cycle with wen=1: r_rdata_o = mem[bank][row] is registered at the
//   clock edge, so the read latency is exactly 1 cycle.
//  Response: r_valid_o[p] = 1 the cycle after every gnt_o[p], for both reads and writes.
//   For a write response, r_rdata_o[p] = 0. Otherwise r_rdata_o keeps its last value.
//  Back-to-back: a port may be granted every cycle, giving one response per cycle.
//   A read issued the cycle after a write to the same word returns the new data.
//  The responder does not require req to stay stable after gnt. Ungranted requests are
//   not queued; the master must hold req until it sees gnt.
//  Reset (also mid-transaction):
//   - gnt_o = 0, r_valid_o = 0, r_rdata_o = 0, rr_q = 0, stall_cnt = 0.
//   - Responses in flight are dropped.
//   - Memory contents are not reset.
//  r_opc_o = 0 at all times.
// TESTING
//  1 Reset, then p0 writes 0xDEADBEEF to 0x0 with be=F, then reads 0x0
//    -> gnt in the same cycle, r_valid 1 cycle later, rdata=0xDEADBEEF.
//  2 Bank conflict: p0 and p1 both read bank 0 (0x0 and 0x10) for 4 cycles
//    -> grants alternate p0,p1,p0,p1. Each response arrives 1 cycle after its own gnt.
//  3 No conflict: p0 reads 0x0 while p1 reads 0x4 (banks 0 and 1)
//    -> both granted every cycle, r_valid=2'b11 each following cycle.
//  4 Byte enables: write 0x11223344 with be=F, then 0xAABBCCDD with be=4'b0101, then read
//    -> 0x11BB33DD.
//  5 STALL_PERIOD=3 with continuous p0 reads -> gnt pattern 1,1,0 repeating.
//    A wrap address 0x4000 (NB_BANKS=4, BANK_WORDS=256) aliases 0x0.
//  6 Assert rst_i in the cycle after a read gnt -> r_valid stays 0 and rdata=0 during
//    reset. Memory data written before reset is still readable after it.

Source files
------------

// File: rtl/pec_tcdm_responder.sv
// Word-interleaved multi-bank TCDM scratchpad: per-bank round-robin arbitration,
// byte-masked writes and a fixed one-cycle response path.
module pec_tcdm_responder #(
   parameter int unsigned NB_PORTS     = 2,
   parameter int unsigned NB_BANKS     = 4,
   parameter int unsigned BANK_WORDS   = 256,
   parameter int unsigned STALL_PERIOD = 0
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NB_PORTS-1:0]       req_i,
   input  logic [NB_PORTS-1:0][31:0] add_i,
   input  logic [NB_PORTS-1:0]       wen_i,
   input  logic [NB_PORTS-1:0][31:0] wdata_i,
   input  logic [NB_PORTS-1:0][3:0]  be_i,
   output logic [NB_PORTS-1:0]       gnt_o,
   output logic [NB_PORTS-1:0]       r_valid_o,
   output logic [NB_PORTS-1:0][31:0] r_rdata_o,
   output logic [NB_PORTS-1:0]       r_opc_o
);

   // NB_PORTS and NB_BANKS are expected to be at least 2.
   localparam int unsigned BankW = $clog2(NB_BANKS);
   localparam int unsigned RowW  = $clog2(BANK_WORDS);
   localparam int unsigned PortW = $clog2(NB_PORTS);

   logic [NB_PORTS-1:0][BankW-1:0]    w_bank;
   logic [NB_PORTS-1:0][RowW-1:0]     w_row;
   logic [NB_PORTS-1:0][31:0]         w_rd;
   logic [NB_BANKS-1:0][NB_PORTS-1:0] w_bank_req;
   logic [NB_PORTS-1:0]               w_gnt;
   logic                              w_stall;
   logic [NB_BANKS-1:0][PortW-1:0]    r_rr;
   logic [NB_BANKS-1:0][PortW-1:0]    w_rr_nxt;
   logic [NB_BANKS-1:0]               w_bwe;
   logic [NB_BANKS-1:0][RowW-1:0]     w_brow;
   logic [NB_BANKS-1:0][31:0]         w_bwdata;
   logic [NB_BANKS-1:0][3:0]          w_bbe;
   logic [NB_PORTS-1:0]               r_valid;
   logic [NB_PORTS-1:0][31:0]         r_rdata;
   logic [31:0]                       r_mem [NB_BANKS][BANK_WORDS];
   logic                              w_unused;

   // Address bits above the row field and add_i[1:0] are intentionally ignored.
   assign w_unused = ^add_i;

   always_comb begin
      w_bank     = '0;
      w_row      = '0;
      w_rd       = '0;
      w_bank_req = '0;
      for (int p = 0; p < NB_PORTS; p++) begin
         w_bank[p] = add_i[p][2 +: BankW];
         w_row[p]  = add_i[p][2 + BankW +: RowW];
         w_rd[p]   = r_mem[w_bank[p]][w_row[p]];
      end
      for (int b = 0; b < NB_BANKS; b++) begin
         for (int p = 0; p < NB_PORTS; p++) begin
            w_bank_req[b][p] = req_i[p] && (w_bank[p] == BankW'(b));
         end
      end
   end

   if (STALL_PERIOD > 0) begin : g_stall
      localparam int unsigned CntW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
      logic [CntW-1:0] r_stall_cnt;

      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            r_stall_cnt <= '0;
         end else if (r_stall_cnt == CntW'(STALL_PERIOD - 1)) begin
            r_stall_cnt <= '0;
         end else begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end

      assign w_stall = (r_stall_cnt == CntW'(STALL_PERIOD - 1));
   end else begin : g_no_stall
      assign w_stall = 1'b0;
   end

   // Search from the bank's pointer; with a single requester this simply finds it.
   always_comb begin
      logic             found;
      logic [PortW-1:0] idx;
      found    = 1'b0;
      idx      = '0;
      w_gnt    = '0;
      w_rr_nxt = r_rr;
      if (!w_stall && !rst_i) begin
         for (int b = 0; b < NB_BANKS; b++) begin
            found = 1'b0;
            for (int unsigned k = 0; k < NB_PORTS; k++) begin
               idx = PortW'((32'(r_rr[b]) + k) % NB_PORTS);
               if (!found && w_bank_req[b][idx]) begin
                  found      = 1'b1;
                  w_gnt[idx] = 1'b1;
                  if ($countones(w_bank_req[b]) > 1) begin
                     w_rr_nxt[b] = PortW'((32'(idx) + 1) % NB_PORTS);
                  end
               end
            end
         end
      end
   end

   always_comb begin
      w_bwe    = '0;
      w_brow   = '0;
      w_bwdata = '0;
      w_bbe    = '0;
      for (int b = 0; b < NB_BANKS; b++) begin
         for (int p = 0; p < NB_PORTS; p++) begin
            if (w_gnt[p] && !wen_i[p] && (w_bank[p] == BankW'(b))) begin
               w_bwe[b]    = 1'b1;
               w_brow[b]   = w_row[p];
               w_bwdata[b] = wdata_i[p];
               w_bbe[b]    = be_i[p];
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NB_BANKS; b++) begin
         if (w_bwe[b]) begin
            for (int i = 0; i < 4; i++) begin
               if (w_bbe[b][i]) begin
                  r_mem[b][w_brow[b]][8*i +: 8] <= w_bwdata[b][8*i +: 8];
               end
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rr    <= '0;
         r_valid <= '0;
         r_rdata <= '0;
      end else begin
         r_rr    <= w_rr_nxt;
         r_valid <= w_gnt;
         for (int p = 0; p < NB_PORTS; p++) begin
            if (w_gnt[p]) begin
               r_rdata[p] <= wen_i[p] ? w_rd[p] : 32'h0;
            end
         end
      end
   end

   // Responses are masked while reset is held so in-flight data never escapes.
   assign gnt_o     = w_gnt;
   assign r_valid_o = rst_i ? '0 : r_valid;
   assign r_rdata_o = rst_i ? '0 : r_rdata;
   assign r_opc_o   = '0;

endmodule

// File: tb/tb_pec_tcdm_responder.sv
// Self-checking bench for pec_tcdm_responder: directed scenarios plus randomized
// traffic against a flat-memory reference model.
module tb_pec_tcdm_responder;

   localparam int          NP = 2;
   localparam int          NB = 4;
   localparam int unsigned NW = 1024;

   logic                clk = 1'b0;
   logic                rst;
   logic [NP-1:0]       req, wen, gnt, rvalid, opc;
   logic [NP-1:0][31:0] add, wdata, rdata;
   logic [NP-1:0][3:0]  be;
   logic [NP-1:0]       s_req, s_wen, s_gnt, s_rvalid, s_opc;
   logic [NP-1:0][31:0] s_add, s_wdata, s_rdata;
   logic [NP-1:0][3:0]  s_be;

   int n_checks = 0;
   int n_pass   = 0;

   int unsigned m_rr [NB];
   logic [31:0] m_mem [int unsigned];
   logic [31:0] m_last [NP];
   bit          m_known [NP];
   logic [NP-1:0] exp_gnt;

   always #5 clk = ~clk;

   pec_tcdm_responder #(.NB_PORTS(2), .NB_BANKS(4), .BANK_WORDS(256), .STALL_PERIOD(0)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen), .wdata_i(wdata),
      .be_i(be), .gnt_o(gnt), .r_valid_o(rvalid), .r_rdata_o(rdata), .r_opc_o(opc)
   );

   pec_tcdm_responder #(.NB_PORTS(2), .NB_BANKS(4), .BANK_WORDS(256), .STALL_PERIOD(3)) dut_s (
      .clk_i(clk), .rst_i(rst), .req_i(s_req), .add_i(s_add), .wen_i(s_wen),
      .wdata_i(s_wdata), .be_i(s_be), .gnt_o(s_gnt), .r_valid_o(s_rvalid),
      .r_rdata_o(s_rdata), .r_opc_o(s_opc)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic r, input logic [31:0] a, input logic w,
                           input logic [31:0] d, input logic [3:0] e);
      req[p]   = r;
      add[p]   = a;
      wen[p]   = w;
      wdata[p] = d;
      be[p]    = e;
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) m_rr[b] = 0;
      for (int p = 0; p < NP; p++) begin
         m_last[p]  = 32'h0;
         m_known[p] = 1'b1;
      end
   endtask

   // Computes this cycle's grants and responses from the current inputs.
   task automatic model_step();
      int unsigned w, cnt, first, p2;
      bit          done;
      logic [31:0] tmp;
      exp_gnt = '0;
      for (int b = 0; b < NB; b++) begin
         cnt = 0;
         first = 0;
         for (int p = 0; p < NP; p++) begin
            if (req[p] && ((add[p] >> 2) % NB) == b) begin
               if (cnt == 0) first = p;
               cnt++;
            end
         end
         if (cnt == 1) exp_gnt[first] = 1'b1;
         else if (cnt > 1) begin
            done = 0;
            for (int k = 0; k < NP; k++) begin
               p2 = (m_rr[b] + k) % NP;
               if (!done && req[p2] && ((add[p2] >> 2) % NB) == b) begin
                  exp_gnt[p2] = 1'b1;
                  m_rr[b] = (p2 + 1) % NP;
                  done = 1;
               end
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (exp_gnt[p]) begin
            w = (add[p] >> 2) % NW;
            if (wen[p]) begin
               m_known[p] = m_mem.exists(w);
               m_last[p]  = m_known[p] ? m_mem[w] : 32'h0;
            end else begin
               m_known[p] = 1'b1;
               m_last[p]  = 32'h0;
            end
         end
      end
      for (int p = 0; p < NP; p++) begin
         if (exp_gnt[p] && !wen[p]) begin
            w = (add[p] >> 2) % NW;
            if (be[p] == 4'hF) m_mem[w] = wdata[p];
            else if (m_mem.exists(w)) begin
               tmp = m_mem[w];
               for (int i = 0; i < 4; i++) if (be[p][i]) tmp[8*i +: 8] = wdata[p][8*i +: 8];
               m_mem[w] = tmp;
            end
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req = '0; add = '0; wen = '0; wdata = '0; be = '0;
      s_req = '0; s_add = '0; s_wen = '0; s_wdata = '0; s_be = '0;
      tick();
      tick();
      req = 2'b11;
      #1;
      n_checks++;
      if (gnt !== 2'b00) $display("FAIL reset_gnt: got %b expected 00", gnt); else n_pass++;
      n_checks++;
      if (rvalid !== 2'b00) $display("FAIL reset_rvalid: got %b expected 00", rvalid);
      else n_pass++;
      n_checks++;
      if (rdata !== 64'h0) $display("FAIL reset_rdata: got %h expected 0", rdata); else n_pass++;
      n_checks++;
      if (opc !== 2'b00) $display("FAIL reset_opc: got %b expected 00", opc); else n_pass++;
      req = '0;
      rst = 1'b0;
      model_reset();
      model_step();
      tick();
      n_checks++;
      if (rvalid !== 2'b00) $display("FAIL post_reset_rvalid: got %b expected 00", rvalid);
      else n_pass++;
   endtask

   task automatic test_write_read();
      set_port(0, 1'b1, 32'h0, 1'b0, 32'hDEADBEEF, 4'hF);
      set_port(1, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      model_step();
      #2;
      n_checks++;
      if (gnt !== 2'b01 || gnt !== exp_gnt) $display("FAIL wr_gnt: got %b expected 01", gnt);
      else n_pass++;
      tick();
      n_checks++;
      if (rvalid !== 2'b01 || rdata[0] !== 32'h0)
         $display("FAIL wr_resp: got valid %b data %h expected 01/0", rvalid, rdata[0]);
      else n_pass++;
      set_port(0, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0);
      model_step();
      #2;
      n_checks++;
      if (gnt !== 2'b01) $display("FAIL rd_gnt: got %b expected 01", gnt); else n_pass++;
      tick();
      n_checks++;
      if (rvalid !== 2'b01 || rdata[0] !== 32'hDEADBEEF || rdata[0] !== m_last[0])
         $display("FAIL rd_resp: got valid %b data %h expected 01/deadbeef", rvalid, rdata[0]);
      else n_pass++;
      req = '0;
   endtask

   task automatic test_conflict();
      set_port(0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      set_port(1, 1'b1, 32'h10, 1'b0, 32'h0BADF00D, 4'hF);
      model_step();
      tick();
      for (int i = 0; i < 4; i++) begin
         set_port(0, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0);
         set_port(1, 1'b1, 32'h10, 1'b1, 32'h0, 4'h0);
         model_step();
         #2;
         n_checks++;
         if (gnt !== exp_gnt || gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10))
            $display("FAIL conflict_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt);
         else n_pass++;
         tick();
         n_checks++;
         if (rvalid !== exp_gnt || rdata[0] !== m_last[0] || rdata[1] !== m_last[1])
            $display("FAIL conflict_resp[%0d]: got %b %h %h expected %b %h %h", i, rvalid,
                     rdata[0], rdata[1], exp_gnt, m_last[0], m_last[1]);
         else n_pass++;
      end
      req = '0;
   endtask

   task automatic test_no_conflict();
      set_port(0, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      set_port(1, 1'b1, 32'h4, 1'b0, $urandom, 4'hF);
      model_step();
      tick();
      for (int i = 0; i < 3; i++) begin
         set_port(0, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0);
         set_port(1, 1'b1, 32'h4, 1'b1, 32'h0, 4'h0);
         model_step();
         #2;
         n_checks++;
         if (gnt !== 2'b11 || gnt !== exp_gnt)
            $display("FAIL noconf_gnt[%0d]: got %b expected 11", i, gnt);
         else n_pass++;
         tick();
         n_checks++;
         if (rvalid !== 2'b11 || rdata[0] !== m_last[0] || rdata[1] !== m_last[1])
            $display("FAIL noconf_resp[%0d]: got %b %h %h expected 11 %h %h", i, rvalid,
                     rdata[0], rdata[1], m_last[0], m_last[1]);
         else n_pass++;
      end
      req = '0;
   endtask

   task automatic test_byte_enable();
      logic [31:0] d [3];
      logic [3:0]  e [3];
      logic        w [3];
      d = '{32'h11223344, 32'hAABBCCDD, 32'h0};
      e = '{4'hF, 4'b0101, 4'h0};
      w = '{1'b0, 1'b0, 1'b1};
      set_port(1, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      for (int i = 0; i < 3; i++) begin
         set_port(0, 1'b1, 32'h8, w[i], d[i], e[i]);
         model_step();
         #2;
         n_checks++;
         if (gnt !== 2'b01) $display("FAIL be_gnt[%0d]: got %b expected 01", i, gnt);
         else n_pass++;
         tick();
      end
      n_checks++;
      if (rvalid[0] !== 1'b1 || rdata[0] !== 32'h11BB33DD || rdata[0] !== m_last[0])
         $display("FAIL be_rdata: got %b %h expected 1 11bb33dd", rvalid[0], rdata[0]);
      else n_pass++;
      req = '0;
   endtask

   task automatic test_random();
      logic [31:0] pool [8];
      pool = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h40, 32'h404};
      set_port(1, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      for (int i = 0; i < 8; i++) begin
         set_port(0, 1'b1, pool[i], 1'b0, $urandom, 4'hF);
         model_step();
         tick();
      end
      for (int c = 0; c < 300; c++) begin
         for (int p = 0; p < NP; p++) begin
            set_port(p, ($urandom_range(0, 3) != 0),
                     pool[$urandom_range(0, 7)] + 32'h1000 * $urandom_range(0, 3)
                        + $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
         end
         model_step();
         #2;
         n_checks++;
         if (gnt !== exp_gnt) $display("FAIL rand_gnt[%0d]: got %b expected %b", c, gnt, exp_gnt);
         else n_pass++;
         tick();
         n_checks++;
         if (rvalid !== exp_gnt)
            $display("FAIL rand_rvalid[%0d]: got %b expected %b", c, rvalid, exp_gnt);
         else n_pass++;
         for (int p = 0; p < NP; p++) begin
            if (m_known[p]) begin
               n_checks++;
               if (rdata[p] !== m_last[p])
                  $display("FAIL rand_rdata[%0d][%0d]: got %h expected %h", c, p, rdata[p],
                           m_last[p]);
               else n_pass++;
            end
         end
      end
      req = '0;
   endtask

   task automatic test_reset_mid();
      set_port(1, 1'b0, 32'h0, 1'b1, 32'h0, 4'h0);
      set_port(0, 1'b1, 32'h20, 1'b0, 32'h5A5A1234, 4'hF);
      model_step();
      tick();
      set_port(0, 1'b1, 32'h20, 1'b1, 32'h0, 4'h0);
      model_step();
      #2;
      n_checks++;
      if (gnt !== 2'b01) $display("FAIL rstmid_gnt: got %b expected 01", gnt); else n_pass++;
      tick();
      rst = 1'b1;
      set_port(1, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0);
      for (int i = 0; i < 2; i++) begin
         #1;
         n_checks++;
         if (gnt !== 2'b00 || rvalid !== 2'b00 || rdata !== 64'h0)
            $display("FAIL rstmid_hold[%0d]: got %b %b %h expected 00 00 0", i, gnt, rvalid,
                     rdata);
         else n_pass++;
         tick();
      end
      rst = 1'b0;
      req = '0;
      model_reset();
      model_step();
      tick();
      n_checks++;
      if (rvalid !== 2'b00 || rdata !== 64'h0)
         $display("FAIL rstmid_after: got %b %h expected 00 0", rvalid, rdata);
      else n_pass++;
      set_port(0, 1'b1, 32'h20, 1'b1, 32'h0, 4'h0);
      set_port(1, 1'b1, 32'h0, 1'b1, 32'h0, 4'h0);
      model_step();
      #2;
      n_checks++;
      if (gnt !== 2'b01 || gnt !== exp_gnt)
         $display("FAIL rstmid_rr: got %b expected 01", gnt);
      else n_pass++;
      tick();
      n_checks++;
      if (rvalid !== 2'b01 || rdata[0] !== 32'h5A5A1234)
         $display("FAIL rstmid_mem: got %b %h expected 01 5a5a1234", rvalid, rdata[0]);
      else n_pass++;
      req = '0;
   endtask

   task automatic test_stall();
      bit got;
      req = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      s_req = 2'b01; s_add = '0; s_wen = 2'b11; s_wdata = '0; s_be = '0;
      for (int i = 0; i < 9; i++) begin
         #2;
         n_checks++;
         if (s_gnt !== ((i % 3 != 2) ? 2'b01 : 2'b00))
            $display("FAIL stall_gnt[%0d]: got %b expected %0d", i, s_gnt, (i % 3 != 2));
         else n_pass++;
         tick();
         n_checks++;
         if (s_rvalid[0] !== (i % 3 != 2) || s_opc !== 2'b00)
            $display("FAIL stall_rvalid[%0d]: got %b expected %0d", i, s_rvalid[0], (i % 3 != 2));
         else n_pass++;
      end
      s_wen[0] = 1'b0; s_wdata[0] = 32'hCAFEF00D; s_be[0] = 4'hF;
      got = 0;
      for (int i = 0; i < 5 && !got; i++) begin
         #2;
         if (s_gnt[0]) got = 1;
         tick();
      end
      n_checks++;
      if (!got) $display("FAIL stall_wr_timeout: got no gnt expected gnt"); else n_pass++;
      s_wen[0] = 1'b1; s_add[0] = 32'h4000;
      got = 0;
      for (int i = 0; i < 5 && !got; i++) begin
         #2;
         if (s_gnt[0]) got = 1;
         tick();
      end
      n_checks++;
      if (!got || s_rvalid[0] !== 1'b1 || s_rdata[0] !== 32'hCAFEF00D)
         $display("FAIL stall_alias: got %0d %b %h expected 1 1 cafef00d", got, s_rvalid[0],
                  s_rdata[0]);
      else n_pass++;
      s_req = '0;
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_conflict();
      test_no_conflict();
      test_byte_enable();
      test_random();
      test_reset_mid();
      test_stall();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
